// File: rtl/operand_stack.sv
// operand_stack: LIFO operand store (DEPTH x N) with push/pop/init/swap, occupancy and sticky err.
// Latency: 1 cycle from command sample to q/q1/count/flags; reads are combinational from state.
// Backpressure: none; a push when full or a pop when empty is dropped and sets err.
// Optional feature: define OPERAND_STACK_SWAP_EN to decode the swap command.
module operand_stack #(
    parameter int              N         = 8,
    parameter int              DEPTH     = 4,
    parameter logic [N-1:0]    RESET_VAL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 D,
    input  logic                         init,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         swap,
    input  logic                         clr_err,
    output logic [N-1:0]                 q,
    output logic [N-1:0]                 q1,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    // Pointer-based storage: entry[cnt-1] is the top, slots above it are stale.
    logic [N-1:0]  mem [DEPTH];
    logic [CW-1:0] cnt;
    logic          err_r;

    logic [AW-1:0] top_idx;
    logic [AW-1:0] sec_idx;
    logic [AW-1:0] new_idx;
    logic          is_empty;
    logic          is_full;
    logic          has_two;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [CW-1:0] cnt_nxt;
    logic          fail;
    logic          do_swap;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CW'(DEPTH));
    assign has_two  = (cnt >= CW'(2));
    assign top_idx  = AW'(cnt - CW'(1));
    assign sec_idx  = AW'(cnt - CW'(2));
    assign new_idx  = AW'(cnt);

`ifndef OPERAND_STACK_SWAP_EN
    // Swap is accepted on the port but has no effect in this build.
    logic unused_swap;
    assign unused_swap = swap;
`endif

    // Command decode with priority init > push > pop > swap.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = new_idx;
        cnt_nxt = cnt;
        fail    = 1'b0;
        do_swap = 1'b0;
        if (init) begin
            if (is_empty) begin
                // An init on an empty stack is a plain push.
                wr_en   = 1'b1;
                wr_idx  = new_idx;
                cnt_nxt = cnt + CW'(1);
            end else begin
                wr_en   = 1'b1;
                wr_idx  = top_idx;
            end
        end else if (push) begin
            if (is_full) begin
                fail    = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = new_idx;
                cnt_nxt = cnt + CW'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                fail    = 1'b1;
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end
`ifdef OPERAND_STACK_SWAP_EN
        else if (swap) begin
            if (has_two) begin
                do_swap = 1'b1;
            end else begin
                fail    = 1'b1;
            end
        end
`endif
    end

    // Storage, occupancy and sticky error update; reset returns every entry to RESET_VAL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
            cnt   <= '0;
            err_r <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= D;
            end
            if (do_swap) begin
                mem[top_idx] <= mem[sec_idx];
                mem[sec_idx] <= mem[top_idx];
            end
            cnt <= cnt_nxt;
            // A failing command in the same cycle as clr_err leaves err set.
            if (fail) begin
                err_r <= 1'b1;
            end else if (clr_err) begin
                err_r <= 1'b0;
            end
        end
    end

    // Read ports hide stale slots behind RESET_VAL so popped data never reappears.
    always_comb begin
        q  = is_empty ? RESET_VAL : mem[top_idx];
        q1 = has_two  ? mem[sec_idx] : RESET_VAL;
    end

    assign count = cnt;
    assign empty = is_empty;
    assign full  = is_full;
    assign err   = err_r;

endmodule
